// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the instruction-memory responder.
package cv32e40p_pkg;

  // Largest legal extra response latency; also sizes the wait counter.
  localparam int unsigned IMEM_MAX_WAIT = 15;
  localparam int unsigned IMEM_CNT_W    = $clog2(IMEM_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_resp_state_e;

endpackage

// File: rtl/cv32e40p_imem_ram.sv
// Word-wide storage: one synchronous write port and one registered read
// port. A read and a write to the same index on one edge return old data.
module cv32e40p_imem_ram #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Both ports use non-blocking updates, so a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cv32e40p_imem_responder.sv
// Instruction-fetch memory model: grant/rvalid handshake, programmable
// response latency, range/alignment error responses and a backdoor loader.
module cv32e40p_imem_responder
  import cv32e40p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 0,   // 0..IMEM_MAX_WAIT
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic                  busy_o
);

  imem_resp_state_e      state_q;
  logic [IMEM_CNT_W-1:0] cnt_q;
  logic [31:0]           addr_q;
  logic                  rvalid_q;
  logic                  err_q;

  logic        accept;
  logic        enter_resp;
  logic [31:0] rd_addr;
  logic [31:0] off;
  logic [32:0] lim;
  logic        rd_err;
  logic [31:0] ram_rdata;

  assign instr_gnt_o = ((state_q == IDLE) || (state_q == RESP)) && !load_we_i;
  assign accept      = instr_req_i && instr_gnt_o;

  // The array is read on the edge that enters RESP: straight from the bus
  // when there is no wait, otherwise from the latched address.
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == IMEM_CNT_W'(1)));
  assign rd_addr    = (state_q == WAIT) ? addr_q : instr_addr_i;

  // Range check in 33 bits so the top limit never wraps. BASE_ADDR is word
  // aligned, so off[1:0] equals the address's byte offset; the upper offset
  // bits are redundant with the limit compare but keep every bit meaningful.
  assign off    = rd_addr - BASE_ADDR;
  assign lim    = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_WIDTH + 2));
  assign rd_err = (off[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                  ({1'b0, rd_addr} >= lim) || (off[31:ADDR_WIDTH+2] != '0);

  cv32e40p_imem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (load_we_i),
    .waddr_i (load_addr_i),
    .wdata_i (load_wdata_i),
    .re_i    (enter_resp),
    .raddr_i (off[ADDR_WIDTH+1:2]),
    .rdata_o (ram_rdata)
  );

  // Handshake FSM with wait counter and registered response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            addr_q <= instr_addr_i;
            if (WAIT_CYCLES == 0) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              err_q    <= rd_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= IMEM_CNT_W'(WAIT_CYCLES);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - IMEM_CNT_W'(1);
          if (cnt_q == IMEM_CNT_W'(1)) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            err_q    <= rd_err;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = rvalid_q && err_q;
  assign instr_rdata_o  = (rvalid_q && !err_q) ? ram_rdata : 32'h0;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_cv32e40p_imem_responder.sv
// Directed bench: three responder instances (no wait, 3-cycle wait with a
// non-zero base, 2-cycle wait) share the stimulus; each phase checks one.
module tb_cv32e40p_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [11:0] la = '0;
  logic [31:0] ld = '0;

  logic g0, rv0, er0, bz0;
  logic g3, rv3, er3, bz3;
  logic g2, rv2, er2, bz2;
  logic [31:0] rd0, rd3, rd2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cv32e40p_imem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0), .instr_err_o(er0),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(ld), .busy_o(bz0));

  cv32e40p_imem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g3), .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .instr_err_o(er3),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(ld), .busy_o(bz3));

  cv32e40p_imem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g2), .instr_rvalid_o(rv2), .instr_rdata_o(rd2), .instr_err_o(er2),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(ld), .busy_o(bz2));

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [11:0] la;
    logic [31:0] ld;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        bz;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic g, input logic rv,
                      input logic [31:0] rd, input logic er, input logic bz);
    chk({tag, ".gnt"},    {31'h0, g3},  {31'h0, g});
    chk({tag, ".rvalid"}, {31'h0, rv3}, {31'h0, rv});
    chk({tag, ".rdata"},  rd3,          rd);
    chk({tag, ".err"},    {31'h0, er3}, {31'h0, er});
    chk({tag, ".busy"},   {31'h0, bz3}, {31'h0, bz});
  endtask

  // One request on the 3-wait instance; optional backdoor write on the
  // edge that enters RESP. Starts at posedge+1 with dut3 idle.
  task automatic req3(input string tag, input logic [31:0] a, input logic do_wr,
                      input logic [11:0] wa, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_er);
    req = 1'b1; addr = a; #1;
    chk3({tag, ".c0"}, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3 && do_wr) begin we = 1'b1; la = wa; ld = wd; end
      #1;
      chk3($sformatf("%s.c%0d", tag, i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      we = 1'b0;
    end
    #1;
    chk3({tag, ".c4"}, 1'b1, 1'b1, exp_rd, exp_er, 1'b1);
    tick();
    #1;
    chk3({tag, ".c5"}, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, and gnt following load_we_i while in reset.
    #3;
    chk("rst.gnt",    {31'h0, g0},  32'h1);
    chk("rst.rvalid", {31'h0, rv0}, 32'h0);
    chk("rst.rdata",  rd0,          32'h0);
    chk("rst.err",    {31'h0, er0}, 32'h0);
    chk("rst.busy",   {31'h0, bz0}, 32'h0);
    we = 1'b1; #1;
    chk("rst.gnt_we", {31'h0, g0}, 32'h0);
    we = 1'b0;
    #8 rst_n = 1'b1;
    tick();

    // Backdoor preload.
    we = 1'b1;
    la = 12'd0;    ld = 32'h0000_0013; tick();
    la = 12'd1;    ld = 32'h0010_0093; tick();
    la = 12'd2;    ld = 32'h0020_0113; tick();
    la = 12'd6;    ld = 32'h6666_6666; tick();
    la = 12'd4095; ld = 32'hDEAD_BEEF; tick();
    we = 1'b0; la = '0; ld = '0;

    //         req  addr          we  la     ld            g  rv rd            er bz
    tv[0]  = '{1'b1, 32'h0,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};
    tv[1]  = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 1, 32'h0000_0013, 0, 1};
    tv[2]  = '{1'b1, 32'h0,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};
    tv[3]  = '{1'b1, 32'h4,    1'b0, 12'd0, 32'h0,        1, 1, 32'h0000_0013, 0, 1};
    tv[4]  = '{1'b1, 32'h8,    1'b0, 12'd0, 32'h0,        1, 1, 32'h0010_0093, 0, 1};
    tv[5]  = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 1, 32'h0020_0113, 0, 1};
    tv[6]  = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};
    tv[7]  = '{1'b1, 32'h2,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};
    tv[8]  = '{1'b1, 32'h4000, 1'b0, 12'd0, 32'h0,        1, 1, 32'h0,        1, 1};
    tv[9]  = '{1'b1, 32'h3FFC, 1'b0, 12'd0, 32'h0,        1, 1, 32'h0,        1, 1};
    tv[10] = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 1, 32'hDEAD_BEEF, 0, 1};
    tv[11] = '{1'b1, 32'h0,    1'b1, 12'd5, 32'h5555_5555, 0, 0, 32'h0,       0, 0};
    tv[12] = '{1'b1, 32'h0,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};
    tv[13] = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 1, 32'h0000_0013, 0, 1};
    tv[14] = '{1'b0, 32'h0,    1'b0, 12'd0, 32'h0,        1, 0, 32'h0,        0, 0};

    for (int i = 0; i < 15; i++) begin
      req = tv[i].req; addr = tv[i].addr; we = tv[i].we; la = tv[i].la; ld = tv[i].ld;
      #1;
      chk($sformatf("v%0d.gnt", i),    {31'h0, g0},  {31'h0, tv[i].g});
      chk($sformatf("v%0d.rvalid", i), {31'h0, rv0}, {31'h0, tv[i].rv});
      chk($sformatf("v%0d.rdata", i),  rd0,          tv[i].rd);
      chk($sformatf("v%0d.err", i),    {31'h0, er0}, {31'h0, tv[i].er});
      chk($sformatf("v%0d.busy", i),   {31'h0, bz0}, {31'h0, tv[i].bz});
      tick();
    end
    req = 1'b0; we = 1'b0;
    repeat (6) tick();

    // 3-wait instance: latency, busy window, gnt low in WAIT, and a request
    // held through WAIT being taken in RESP.
    req = 1'b1; addr = 32'h1000; #1;
    chk3("w3.c0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    addr = 32'h1004;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk3($sformatf("w3.c%0d", i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    #1;
    chk3("w3.c4", 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    tick();
    req = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      #1;
      chk3($sformatf("w3.c%0d", i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    #1;
    chk3("w3.c8", 1'b1, 1'b1, 32'h0010_0093, 1'b0, 1'b1);
    tick();
    #1;
    chk3("w3.c9", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Read-before-write on the RESP-entering edge, then the new data.
    req3("rbw",  32'h1018, 1'b1, 12'd6, 32'h7777_7777, 32'h6666_6666, 1'b0);
    tick();
    req3("new",  32'h1018, 1'b0, 12'd0, 32'h0,         32'h7777_7777, 1'b0);
    tick();
    // Below base, and last valid word / first word past the top.
    req3("low",  32'h0FFC, 1'b0, 12'd0, 32'h0,         32'h0,         1'b1);
    tick();
    req3("last", 32'h4FFC, 1'b0, 12'd0, 32'h0,         32'hDEAD_BEEF, 1'b0);
    tick();
    req3("top",  32'h5000, 1'b0, 12'd0, 32'h0,         32'h0,         1'b1);
    repeat (3) tick();

    // 2-wait instance: reset one cycle after the grant drops the request.
    req = 1'b1; addr = 32'h0; #1;
    chk("r2.gnt", {31'h0, g2}, 32'h1);
    tick();
    req = 1'b0;
    chk("r2.busy_wait", {31'h0, bz2}, 32'h1);
    rst_n = 1'b0; #1;
    chk("r2.busy_rst", {31'h0, bz2}, 32'h0);
    chk("r2.gnt_rst",  {31'h0, g2},  32'h1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("r2.rvalid%0d", i), {31'h0, rv2}, 32'h0);
      chk($sformatf("r2.busy%0d", i),   {31'h0, bz2}, 32'h0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
